// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and helpers for the data memory arbiter
package dmem_arb_pkg;

    localparam int WAIT_CNT_W = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  bmask;
        logic [31:0] wdata;
    } dmem_req_t;

    // True when no address bits above the memory window are set.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned dmem_w);
        return (addr >> dmem_w) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// rtl/dmem_arb_picker.sv - fixed-priority winner select with starvation override
module dmem_arb_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] starved,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic starved_any;

    always_comb begin
        idx         = '0;
        any         = 1'b0;
        starved_any = 1'b0;
        grant       = '0;
        // Scanning downwards leaves the lowest matching index as winner.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starved[i]) begin
                idx         = IDX_W'(i);
                starved_any = 1'b1;
            end
        end
        if (starved_any) begin
            any = 1'b1;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (valid[i]) begin
                    idx = IDX_W'(i);
                    any = 1'b1;
                end
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory among NUM_REQ requesters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int DMEM_W   = 11,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*4-1:0]  req_bmask,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [DMEM_W-1:0]     mem_addr,
    output logic [3:0]            mem_bmask,
    output logic                  mem_wr_en,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [WAIT_CNT_W-1:0] wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]    starved;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;
    logic                  granted;
    logic                  win_in_range;
    dmem_req_t             reqs [NUM_REQ];
    dmem_req_t             win;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].addr  = req_addr[i*32 +: 32];
            reqs[i].we    = req_we[i];
            reqs[i].bmask = req_bmask[i*4 +: 4];
            reqs[i].wdata = req_wdata[i*32 +: 32];
            starved[i]    = req_valid[i] && (wait_cnt[i] >= WAIT_CNT_W'(MAX_WAIT));
        end
    end

    dmem_arb_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .valid   (req_valid),
        .starved (starved),
        .grant   (grant_oh),
        .idx     (win_idx),
        .any     (win_any)
    );

    // Reset gates the grant so nothing transfers and no write escapes while rst_n is low.
    always_comb begin
        win          = reqs[win_idx];
        win_in_range = in_range(win.addr, DMEM_W);
        granted      = rst_n && win_any;
        req_ready    = granted ? grant_oh : '0;
        mem_addr     = granted ? win.addr[DMEM_W-1:0] : '0;
        mem_bmask    = granted ? win.bmask : 4'h0;
        mem_wdata    = granted ? win.wdata : 32'h0;
        mem_wr_en    = granted && win.we && win_in_range;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            rsp_valid <= req_ready;
            rsp_err   <= granted && !win_in_range;
            if (granted) begin
                rsp_rdata <= (!win.we && win_in_range) ? mem_rdata : 32'h0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i]) begin
                    if (wait_cnt[i] != '1) begin
                        wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_we;
    logic [7:0]  req_bmask;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [10:0] mem_addr;
    logic [3:0]  mem_bmask;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [1:0]  s_rsp_valid;
    logic        s_rsp_err;
    logic [31:0] s_rsp_rdata;
    logic [10:0] s_mem_addr;
    logic [3:0]  s_mem_bmask;
    logic        s_mem_wr_en;
    logic [31:0] s_mem_wdata;

    logic [31:0] mem [512];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_REQ(2), .DMEM_W(11), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_bmask(req_bmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_bmask(mem_bmask), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Second instance with the longest promotion threshold, for saturation.
    dmem_arbiter #(.NUM_REQ(2), .DMEM_W(11), .MAX_WAIT(255)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_valid), .req_ready(s_ready), .req_addr(64'h0),
        .req_we(2'b00), .req_bmask(8'h0), .req_wdata(64'h0),
        .rsp_valid(s_rsp_valid), .rsp_err(s_rsp_err), .rsp_rdata(s_rsp_rdata),
        .mem_addr(s_mem_addr), .mem_bmask(s_mem_bmask), .mem_wr_en(s_mem_wr_en),
        .mem_wdata(s_mem_wdata), .mem_rdata(32'h0)
    );

    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_bmask[b]) mem[mem_addr[10:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic we,
                           input logic [3:0] bm, input logic [31:0] wd);
        req_valid[p]         = v;
        req_addr[p*32 +: 32] = a;
        req_we[p]            = we;
        req_bmask[p*4 +: 4]  = bm;
        req_wdata[p*32 +: 32] = wd;
    endtask

    initial begin
        int first_g;
        int second_g;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        s_valid = 2'b00;
        req_valid = 2'b00; req_addr = '0; req_we = '0; req_bmask = '0; req_wdata = '0;

        // Reset with every port requesting a write
        set_req(0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h11111111);
        set_req(1, 1'b1, 32'h14, 1'b1, 4'hF, 32'h22222222);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_wr_en", 32'(mem_wr_en), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_rdata", rsp_rdata, 32'h0);
        end

        // Full-word write then read on port 0
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        set_req(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        #1;
        check("wr_ready", 32'(req_ready), 32'h1);
        check("wr_en", 32'(mem_wr_en), 32'h1);
        check("wr_addr", 32'(mem_addr), 32'h10);
        @(negedge clk);
        check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        check("wr_rsp_err", 32'(rsp_err), 32'h0);
        set_req(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        #1;
        check("rd_wr_en", 32'(mem_wr_en), 32'h0);
        @(negedge clk);
        check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_err", 32'(rsp_err), 32'h0);

        // Byte-lane write
        set_req(0, 1'b1, 32'h10, 1'b1, 4'b0001, 32'h000000AA);
        @(negedge clk);
        check("bw_rsp_valid", 32'(rsp_valid), 32'h1);
        set_req(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("bw_rdata", rsp_rdata, 32'hDEADBEAA);

        // Priority with starvation promotion: period of 5 cycles
        set_req(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b1, 32'h14, 1'b0, 4'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("prio_%0d", k), 32'(req_ready), (k % 5 == 4) ? 32'h2 : 32'h1);
            @(negedge clk);
        end

        // Withdrawal clears port 1's wait count
        #1; check("wd_a", 32'(req_ready), 32'h1);
        @(negedge clk); #1; check("wd_b", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1; check("wd_c", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("wd_resume_%0d", k), 32'(req_ready), (k == 4) ? 32'h2 : 32'h1);
            @(negedge clk);
        end

        // Out-of-range read on port 1
        set_req(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b1, 32'h800, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("oor_rd_valid", 32'(rsp_valid), 32'h2);
        check("oor_rd_err", 32'(rsp_err), 32'h1);
        check("oor_rd_rdata", rsp_rdata, 32'h0);
        set_req(1, 1'b1, 32'h800, 1'b1, 4'hF, 32'h12345678);
        #1;
        check("oor_wr_ready", 32'(req_ready), 32'h2);
        check("oor_wr_en", 32'(mem_wr_en), 32'h0);
        @(negedge clk);
        check("oor_wr_err", 32'(rsp_err), 32'h1);
        set_req(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_req(0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("oor_mem_kept", rsp_rdata, 32'h0);
        check("inrange_err", 32'(rsp_err), 32'h0);

        // Reset mid-operation drops the pending response and blocks writes
        set_req(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h55555555);
        #1;
        check("mid_rst_wr_en", 32'(mem_wr_en), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("mid_rst_mem_kept", rsp_rdata, 32'hDEADBEAA);
        set_req(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

        // Long wait at MAX_WAIT=255: port 1 wins after 255 losses, then waits 255 again
        @(negedge clk);
        s_valid = 2'b11;
        first_g = -1;
        second_g = -1;
        for (int c = 0; c < 600 && second_g < 0; c++) begin
            #1;
            if (s_ready[1]) begin
                if (first_g < 0) first_g = c;
                else second_g = c;
            end
            @(negedge clk);
        end
        check("sat_first_grant", 32'(first_g), 32'd255);
        check("sat_second_grant", 32'(second_g), 32'd511);
        s_valid = 2'b00;

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
